// File: rtl/gray_pkg.sv
// Shared definitions for the round-robin Gray-to-binary scheduler.
// Holds the FSM state encoding, the default sizes and the id-width helper.
package gray_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Width of a requester index; a single requester bit still needs one wire.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gray2bin_serial.sv
// Bit-serial Gray-to-binary converter, MSB first; done_o is high during the last of WIDTH cycles.
// Latency WIDTH cycles after start_i; no backpressure, start_i must only be issued while idle.
module gray2bin_serial
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] gray_i,
  output logic             done_o,
  output logic [WIDTH-1:0] bin_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-2:0] bin_q;
  logic [CW-1:0]    cnt_q;
  logic             act_q;
  logic             bit_c;
  logic [WIDTH-1:0] bin_d;

  // bin_q[0] is the previously produced bit b[i+1]; it is cleared on start so b[MSB]=g[MSB].
  assign bit_c  = sh_q[WIDTH-1] ^ bin_q[0];
  assign bin_d  = {bin_q, bit_c};
  assign done_o = act_q && (cnt_q == '0);
  assign bin_o  = bin_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      bin_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (start_i) begin
      sh_q  <= gray_i;
      bin_q <= '0;
      cnt_q <= CW'(WIDTH - 1);
      act_q <= 1'b1;
    end else if (act_q) begin
      sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
      bin_q <= bin_d[WIDTH-2:0];
      if (cnt_q == '0) begin
        act_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/gray2bin_rr_sched.sv
// Round-robin scheduler sharing one serial Gray-to-binary converter among N_REQ requesters.
// gnt at T, out_valid pulse at T+WIDTH+1; no backpressure, grants only issued when idle.
module gray2bin_rr_sched
  import gray_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   gray_in,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic [WIDTH-1:0]         bin_out,
  output logic [id_w(N_REQ)-1:0]   out_id,
  output logic                     out_valid
);

  localparam int IDW = id_w(N_REQ);
  localparam logic [IDW-1:0] LAST = IDW'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] bin_out_q;
  logic [IDW-1:0]   out_id_q;

  logic             pick_vld;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   scan_idx;
  logic [WIDTH-1:0] gray_sel;
  logic             start;
  logic             conv_done;
  logic [WIDTH-1:0] conv_bin;

  // Scan from ptr with explicit wrap so non-power-of-two N_REQ stays in range.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_vld && req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
      scan_idx = (scan_idx == LAST) ? '0 : scan_idx + IDW'(1);
    end
  end

  always_comb begin
    gray_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_idx == IDW'(k)) gray_sel = gray_in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          start   = 1'b1;
          id_d    = pick_idx;
          ptr_d   = (pick_idx == LAST) ? '0 : pick_idx + IDW'(1);
          state_d = S_CONV;
        end
      end
      S_CONV:  if (conv_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      bin_out_q <= '0;
      out_id_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      if (state_q == S_CONV && conv_done) begin
        bin_out_q <= conv_bin;
        out_id_q  <= id_q;
      end
    end
  end

  gray2bin_serial #(.WIDTH(WIDTH)) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .gray_i  (gray_sel),
    .done_o  (conv_done),
    .bin_o   (conv_bin)
  );

  // Grant is a decode of the idle-state pick; gated by rst_n so it drops with reset.
  always_comb begin
    gnt = '0;
    for (int k = 0; k < N_REQ; k++) begin
      gnt[k] = rst_n && start && (pick_idx == IDW'(k));
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign bin_out   = bin_out_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_gray2bin_rr_sched.sv
// Scoreboard bench for gray2bin_rr_sched: grants push expected words, a monitor pops on out_valid.
module tb_gray2bin_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] gray_in = '0;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  bin_out;
  logic [1:0]  out_id;
  logic        out_valid;

  gray2bin_rr_sched #(.N_REQ(4), .WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gray_in   (gray_in),
    .gnt       (gnt),
    .busy      (busy),
    .bin_out   (bin_out),
    .out_id    (out_id),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int mptr = 0;
  logic [5:0] exp_q[$];

  // Hand-computed binary value for each 4-bit Gray code 0..15.
  logic [3:0] G2B [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                           4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rr_exp(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++) begin
      int k;
      k = (p + off) % 4;
      if (r[k]) return 4'(1 << k);
    end
    return 4'b0000;
  endfunction

  // Waits (from now) for a grant, checks it against the rotation model, queues the expected word.
  task automatic wait_gnt(input string name, output int t);
    bit seen;
    logic [3:0] e;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (gnt != 4'b0000) seen = 1'b1;
      else @(negedge clk);
    end
    t = cyc;
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no gnt within 40 cycles, expected a grant", name);
      return;
    end
    e = rr_exp(req, mptr);
    check(name, gnt, e);
    for (int k = 0; k < 4; k++) begin
      if (e[k]) begin
        exp_q.push_back({2'(k), G2B[gray_in[k*4 +: 4]]});
        mptr = (k + 1) % 4;
      end
    end
  endtask

  task automatic wait_valid(input string name, output int t);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (out_valid) seen = 1'b1;
      else @(negedge clk);
    end
    t = cyc;
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no out_valid within 20 cycles, expected one", name);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_unexpected: got id=%0d bin=%b, expected no output", out_id, bin_out);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        check("out_id_bin", {26'd0, out_id, bin_out}, {26'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, tp, n0;
    bit bad;

    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_bin_out", bin_out, 0);
    check("rst_out_id", out_id, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 2: 1011 -> 1101, latency 5.
    @(negedge clk);
    gray_in[11:8] = 4'b1011;
    req = 4'b0100;
    wait_gnt("t2_gnt", tp);
    check("t2_busy_at_gnt", busy, 0);
    @(negedge clk);
    req = 4'b0000;
    #1;
    check("t2_busy_conv", busy, 1);
    wait_valid("t2_valid", t);
    check("t2_latency", t - tp, 5);
    drain("t2_drain");

    // Reset two cycles after a grant: outputs clear at once, the word is lost.
    @(negedge clk);
    gray_in[3:0] = 4'b0011;
    req = 4'b0001;
    wait_gnt("t1_gnt", tp);
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req = 4'b1111;
    #1;
    check("t1_gnt_rst", gnt, 0);
    check("t1_busy_rst", busy, 0);
    check("t1_ov_rst", out_valid, 0);
    check("t1_bin_rst", bin_out, 0);
    check("t1_id_rst", out_id, 0);
    exp_q.delete();
    mptr = 0;
    gray_in = {4'b0001, 4'b1011, 4'b1000, 4'b0110};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All requests held: strict rotation starting at req[0], 6 cycles apart.
    wait_gnt("t4_gnt0", tp);
    check("t1_first_gnt", gnt, 4'b0001);
    for (int j = 1; j < 5; j++) begin
      @(negedge clk);
      wait_gnt($sformatf("t4_gnt%0d", j), t);
      check($sformatf("t4_spacing%0d", j), t - tp, 6);
      tp = t;
    end
    @(negedge clk);
    req = 4'b0000;
    drain("t4_drain");

    // Every Gray code through requester 0; gray_in changes during each conversion.
    @(negedge clk);
    req = 4'b0001;
    for (int g = 0; g < 16; g++) begin
      gray_in[3:0] = 4'(g);
      wait_gnt($sformatf("t3_gnt%0d", g), t);
      @(negedge clk);
    end
    req = 4'b0000;
    drain("t3_drain");

    // req[1] raised during conversion of req[0]: granted in the cycle after out_valid.
    @(negedge clk);
    gray_in[3:0] = 4'b1100;
    req = 4'b0001;
    wait_gnt("t5_gnt0", tp);
    @(negedge clk);
    req = 4'b0010;
    gray_in[7:4] = 4'b1110;
    bad = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      if (gnt != 4'b0000) bad = 1'b1;
      if (i == 5) check("t5_out_valid", out_valid, 1);
      @(negedge clk);
    end
    check("t5_no_early_gnt", bad, 0);
    wait_gnt("t5_gnt1", t);
    check("t5_gnt1_delay", t - tp, 6);
    @(negedge clk);
    req = 4'b0000;
    drain("t5_drain");

    // Fairness: req[0] held, req[3] raised later, served after at most one more req[0] grant.
    @(negedge clk);
    gray_in[3:0] = 4'b0101;
    gray_in[15:12] = 4'b1111;
    req = 4'b0001;
    wait_gnt("t6_gnt_first", t);
    repeat (3) @(negedge clk);
    req = 4'b1001;
    n0 = 0;
    for (int j = 0; j < 6; j++) begin
      wait_gnt($sformatf("t6_gnt%0d", j), t);
      if (gnt == 4'b1000) break;
      n0++;
      @(negedge clk);
    end
    check("t6_req0_grants_before_req3", n0, 0);
    @(negedge clk);
    req = 4'b0000;
    drain("t6_drain");

    repeat (8) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
